red_pitaya_iq_gain_ramp_ctrl: RTL and testbench
===============================================

// Module: red_pitaya_iq_gain_ramp_ctrl
// PURPOSE
//  Sequencer for the four IQ-modulator gains (g1..g4). Software stages new
//  targets; the block moves all four gain outputs from their present values to
//  the targets along a linear ramp, which avoids output steps. A move can start
//  at once or be aligned to an NCO phase-wrap strobe. Sits between the
//  register bus and the gain inputs of the IQ modulator block.
// PARAMETERS
//  GAINBITS  16  width of the signed gains
//  MAXSHIFT  10  maximum ramp_shift_i value; the ramp has 2**ramp_shift_i steps
//  DIVBITS   16  width of the step prescaler
// PORTS
//  clk_i         in   1         system clock
//  rstn_i        in   1         reset, asynchronous, active-low
//  tgt_g1_i      in   GAINBITS  signed target for g1 (g2_i, g3_i, g4_i identical)
//  ramp_shift_i  in   4         log2 of the number of ramp steps, 0..MAXSHIFT
//  ramp_div_i    in   DIVBITS   clock cycles per step, minus 1
//  sync_en_i     in   1         1 = wait for phase_sync_i before ramping
//  phase_sync_i  in   1         one-cycle NCO phase-wrap strobe
//  start_i       in   1         one-cycle start request
//  abort_i       in   1         one-cycle abort request
//  g1_o..g4_o    out  GAINBITS  signed gains to the modulator
//  busy_o        out  1         state != IDLE
//  done_o        out  1         one-cycle pulse when a ramp completes
//  state_o       out  2         IDLE=0, ARMED=1, RAMP=2
// BEHAVIOUR
//  Reset (rstn_i low, any time, including mid-ramp): state IDLE; g*_o = 0;
//   accumulators, counters, done_o and busy_o = 0.
//  IDLE: start_i=1 (and abort_i=0) latches tgt_g*_i, ramp_shift_i (S) and
//   ramp_div_i (D). Per gain: acc = cur<<<S, delta = tgt-cur (GAINBITS+1 bits,
//   signed). Next state is ARMED if sync_en_i=1, otherwise RAMP. Input changes
//   after the latch are ignored until the next start.
//  ARMED: stay until phase_sync_i=1, then go to RAMP. A phase_sync_i on the
//   same edge as start_i does NOT count.
//  RAMP: on entry, prescaler = 0 and step counter = 0. Each edge: prescaler==D
//   -> prescaler=0, acc += delta, step++; otherwise prescaler++.
//   g*_o = acc >>> S (arithmetic, floor), registered. After step 2**S,
//   acc == tgt<<<S exactly, so g*_o == tgt. done_o=1 for one cycle and the
//   next state is IDLE.
//  Accumulator width is GAINBITS+1+MAXSHIFT. Values move monotonically between
//   the start and target values, so no saturation is needed and the outputs
//   never wrap.
//  Timing: with the start (or sync) accepted at edge E, step k lands at edge
//   E+k*(D+1). The final value and done_o appear after edge E+2**S*(D+1).
//   S=0 and D=0 give a 1-cycle update.
//  start_i in ARMED or RAMP: ignored, no queueing.
//  abort_i in any state: next state IDLE; g*_o hold their present values;
//   done_o is not pulsed. Abort and start on the same edge: abort wins and the
//   start is dropped.
//  ramp_shift_i > MAXSHIFT: clamped to MAXSHIFT when latched.
//  All four gains share S, D and the step timing; they reach their targets on
//   the same edge.
// TESTING
//  1 Reset: hold rstn_i low -> g*_o=0, busy_o=0, state_o=0. Release -> stays IDLE.
//  2 Immediate: S=0, D=0, tgt_g1=0x1000, start -> g1_o=0x1000 one edge later;
//   done_o pulses once; busy_o high for exactly 1 cycle.
//  3 Ramp: S=2, D=1, g1 0->100, g4 100->-3 -> g1 = 25,50,75,100 and
//   g4 = 74,48,22,-3, updating every 2 cycles; done_o with the last step.
//  4 Extremes: S=MAXSHIFT, D=0, g3 -32768->32767 -> monotonic, no wrap,
//   ends at exactly 32767 after 1024 cycles.
//  5 Sync: sync_en=1, start, 50 cycles without phase_sync -> ARMED, outputs
//   unchanged. One phase_sync pulse -> RAMP starts; first step D+1 edges later.
//  6 Abort/reset: abort+start during step 3 of 4 -> IDLE, outputs frozen, no
//   done_o. A second start ramps from the frozen values. rstn_i low mid-ramp
//   -> immediate zeros.

Source files
------------

// File: rtl/red_pitaya_iq_gain_ramp_ctrl.sv
// Four-channel IQ gain sequencer: moves g1..g4 from their present values to
// staged targets along a shared linear ramp, optionally aligned to NCO phase wrap.
module red_pitaya_iq_gain_ramp_ctrl #(
   parameter int GAINBITS = 16,
   parameter int MAXSHIFT = 10,
   parameter int DIVBITS  = 16
)(
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [GAINBITS-1:0] tgt_g1_i,
   input  logic [GAINBITS-1:0] tgt_g2_i,
   input  logic [GAINBITS-1:0] tgt_g3_i,
   input  logic [GAINBITS-1:0] tgt_g4_i,
   input  logic [3:0]          ramp_shift_i,
   input  logic [DIVBITS-1:0]  ramp_div_i,
   input  logic                sync_en_i,
   input  logic                phase_sync_i,
   input  logic                start_i,
   input  logic                abort_i,
   output logic [GAINBITS-1:0] g1_o,
   output logic [GAINBITS-1:0] g2_o,
   output logic [GAINBITS-1:0] g3_o,
   output logic [GAINBITS-1:0] g4_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [1:0]          state_o
);

   localparam int AW = GAINBITS + 1 + MAXSHIFT;
   localparam int DW = GAINBITS + 1;
   localparam int SW = MAXSHIFT + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] RAMP  = 2'd2;

   localparam logic [3:0] MAXS = 4'(MAXSHIFT);

   function automatic logic [3:0] clamp_shift(input logic [3:0] s);
      return (s > MAXS) ? MAXS : s;
   endfunction

   // Arithmetic right shift floors toward minus infinity, which is what makes
   // the final step land exactly on the target for negative values too.
   function automatic logic signed [GAINBITS-1:0] acc_to_gain(
      input logic signed [AW-1:0] a,
      input logic [3:0]           s
   );
      return GAINBITS'(a >>> s);
   endfunction

   logic [1:0]                 state;
   logic [3:0]                 shift;
   logic [DIVBITS-1:0]         div;
   logic [DIVBITS-1:0]         presc;
   logic [SW-1:0]              step;
   logic [SW-1:0]              step_last;
   logic                       done;

   logic signed [GAINBITS-1:0] tgt_in   [4];
   logic signed [GAINBITS-1:0] gain     [4];
   logic signed [AW-1:0]       acc      [4];
   logic signed [AW-1:0]       acc_nxt  [4];
   logic signed [AW-1:0]       acc_init [4];
   logic signed [DW-1:0]       delta    [4];
   logic signed [DW-1:0]       delta_in [4];
   logic [3:0]                 shift_c;
   logic [SW-1:0]              last_c;

   assign tgt_in[0] = tgt_g1_i;
   assign tgt_in[1] = tgt_g2_i;
   assign tgt_in[2] = tgt_g3_i;
   assign tgt_in[3] = tgt_g4_i;

   assign g1_o    = gain[0];
   assign g2_o    = gain[1];
   assign g3_o    = gain[2];
   assign g4_o    = gain[3];
   assign busy_o  = (state != IDLE);
   assign done_o  = done;
   assign state_o = state;

   assign shift_c = clamp_shift(ramp_shift_i);
   assign last_c  = (SW'(1) << shift_c) - SW'(1);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         acc_nxt[i]  = acc[i] + AW'(delta[i]);
         acc_init[i] = AW'(gain[i]) <<< shift_c;
         delta_in[i] = DW'(tgt_in[i]) - DW'(gain[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         shift     <= '0;
         div       <= '0;
         presc     <= '0;
         step      <= '0;
         step_last <= '0;
         done      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            gain[i]  <= '0;
            acc[i]   <= '0;
            delta[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         // Abort wins over everything, including a start on the same edge.
         if (abort_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     shift     <= shift_c;
                     div       <= ramp_div_i;
                     step_last <= last_c;
                     presc     <= '0;
                     step      <= '0;
                     for (int i = 0; i < 4; i++) begin
                        acc[i]   <= acc_init[i];
                        delta[i] <= delta_in[i];
                     end
                     state <= sync_en_i ? ARMED : RAMP;
                  end
               end
               ARMED: begin
                  if (phase_sync_i) begin
                     presc <= '0;
                     step  <= '0;
                     state <= RAMP;
                  end
               end
               RAMP: begin
                  if (presc == div) begin
                     presc <= '0;
                     step  <= step + SW'(1);
                     for (int i = 0; i < 4; i++) begin
                        acc[i]  <= acc_nxt[i];
                        gain[i] <= acc_to_gain(acc_nxt[i], shift);
                     end
                     if (step == step_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end else begin
                     presc <= presc + DIVBITS'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_red_pitaya_iq_gain_ramp_ctrl.sv
// Directed bench for the IQ gain ramp sequencer with hand-computed expectations.
module tb_red_pitaya_iq_gain_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] tgt1 = '0, tgt2 = '0, tgt3 = '0, tgt4 = '0;
   logic [3:0]  shift = '0;
   logic [15:0] div = '0;
   logic        sync_en = 1'b0, phase_sync = 1'b0, start = 1'b0, abort = 1'b0;
   logic signed [15:0] g1, g2, g3, g4;
   logic        busy, done;
   logic [1:0]  state;

   int checks = 0;
   int failures = 0;

   red_pitaya_iq_gain_ramp_ctrl #(.GAINBITS(16), .MAXSHIFT(10), .DIVBITS(16)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .tgt_g1_i(tgt1), .tgt_g2_i(tgt2), .tgt_g3_i(tgt3), .tgt_g4_i(tgt4),
      .ramp_shift_i(shift), .ramp_div_i(div),
      .sync_en_i(sync_en), .phase_sync_i(phase_sync),
      .start_i(start), .abort_i(abort),
      .g1_o(g1), .g2_o(g2), .g3_o(g3), .g4_o(g4),
      .busy_o(busy), .done_o(done), .state_o(state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // S=0, D=0 move used to set up known starting gains.
   task automatic load_now(input int v1, input int v2, input int v3, input int v4);
      tgt1 = 16'(v1); tgt2 = 16'(v2); tgt3 = 16'(v3); tgt4 = 16'(v4);
      shift = 4'd0; div = 16'd0; sync_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      longint a;
      int exp3;

      // 1: reset
      tick(); tick();
      check_eq("rst_g1", g1, 0);
      check_eq("rst_g4", g4, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_state", state, 0);
      check_eq("rst_done", done, 0);
      rstn = 1'b1;
      tick(); tick(); tick();
      check_eq("rel_state", state, 0);

      // 2: immediate update
      tgt1 = 16'h1000; shift = 4'd0; div = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("imm_busy_E", busy, 1);
      check_eq("imm_state_E", state, 2);
      check_eq("imm_g1_E", g1, 0);
      tick();
      check_eq("imm_g1", g1, 4096);
      check_eq("imm_done", done, 1);
      check_eq("imm_busy_off", busy, 0);
      check_eq("imm_g2", g2, 0);
      tick();
      check_eq("imm_done_once", done, 0);

      // 3: ramp S=2 D=1, g1 0->100, g4 100->-3
      load_now(0, 0, 0, 100);
      check_eq("r_pre_g4", g4, 100);
      tgt1 = 16'd100; tgt4 = -16'sd3; shift = 4'd2; div = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_eq("r_g1_E1", g1, 0);
      tick();
      check_eq("r_g1_s1", g1, 25);
      check_eq("r_g4_s1", g4, 74);
      tick();
      check_eq("r_g1_hold", g1, 25);
      tick();
      check_eq("r_g1_s2", g1, 50);
      check_eq("r_g4_s2", g4, 48);
      tick(); tick();
      check_eq("r_g1_s3", g1, 75);
      check_eq("r_g4_s3", g4, 22);
      check_eq("r_nodone_s3", done, 0);
      tick(); tick();
      check_eq("r_g1_s4", g1, 100);
      check_eq("r_g4_s4", g4, -3);
      check_eq("r_done", done, 1);
      tick();
      check_eq("r_done_off", done, 0);
      check_eq("r_state_idle", state, 0);

      // 4: extremes, shift request 15 is clamped to 10
      load_now(100, 0, -32768, -3);
      check_eq("x_pre_g3", g3, -32768);
      tgt3 = 16'sd32767; shift = 4'd15; div = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 1024; k++) begin
         tick();
         a = (longint'(-32768) * 1024 + longint'(k) * 65535) >>> 10;
         exp3 = int'(a);
         check_eq("x_g3_step", g3, exp3);
         check_eq("x_done", done, (k == 1024) ? 1 : 0);
      end
      check_eq("x_g3_final", g3, 32767);
      check_eq("x_g1_hold", g1, 100);
      check_eq("x_g4_hold", g4, -3);
      check_eq("x_state", state, 0);

      // 5: sync; phase_sync coincident with start does not count
      tgt1 = 16'd200; tgt3 = 16'sd32767; shift = 4'd1; div = 16'd2;
      sync_en = 1'b1; start = 1'b1; phase_sync = 1'b1;
      tick();
      start = 1'b0; phase_sync = 1'b0;
      check_eq("s_armed", state, 1);
      for (int k = 0; k < 50; k++) tick();
      check_eq("s_still_armed", state, 1);
      check_eq("s_g1_unch", g1, 100);
      check_eq("s_busy", busy, 1);
      phase_sync = 1'b1;
      tick();
      phase_sync = 1'b0;
      check_eq("s_ramp", state, 2);
      tick(); tick();
      check_eq("s_g1_E2", g1, 100);
      tick();
      check_eq("s_g1_s1", g1, 150);
      tick(); tick(); tick();
      check_eq("s_g1_s2", g1, 200);
      check_eq("s_done", done, 1);
      sync_en = 1'b0;

      // 6: abort + start during step 3 of 4
      tgt1 = 16'd0; shift = 4'd2; div = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_eq("a_g1_s1", g1, 150);
      tick();
      check_eq("a_g1_s2", g1, 100);
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check_eq("a_state", state, 0);
      check_eq("a_g1_frozen", g1, 100);
      check_eq("a_no_done", done, 0);
      tick(); tick();
      check_eq("a_still_idle", state, 0);
      check_eq("a_g1_frozen2", g1, 100);
      check_eq("a_no_done2", done, 0);
      tgt1 = -16'sd100; shift = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_eq("a2_g1_s1", g1, 0);
      tick();
      check_eq("a2_g1_s2", g1, -100);
      check_eq("a2_done", done, 1);

      // reset mid-ramp
      tick();
      tgt1 = 16'd1500; shift = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check_eq("m_g1_s2", g1, 300);
      #2 rstn = 1'b0;
      #1;
      check_eq("m_rst_g1", g1, 0);
      check_eq("m_rst_g4", g4, 0);
      check_eq("m_rst_state", state, 0);
      check_eq("m_rst_busy", busy, 0);
      tick();
      rstn = 1'b1;
      tick(); tick();
      check_eq("m_after_state", state, 0);
      check_eq("m_after_g1", g1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
